// File: rtl/bkm_control_seq.sv
// bkm_control_seq: iteration sequencer for the BKM control path.
// Captures u_0/v_0, mode, format and n_last on an accepted start. It presents
// u_n, v_n, n, mode and format to the combinational bkm_control_step. It
// commits step_u_np1/step_v_np1 back into u_n/v_n for n = 0..n_last, then
// returns the final u/v together with a one-cycle done pulse.
//
// Ports:
//   clk, arst (async, active high), srst (sync, active high, gated by enable)
//   enable                 clock enable; all state and outputs hold when low
//   start                  start request, honoured only in IDLE
//   mode, format, n_last   run parameters, captured on accepted start
//   u_0, v_0               initial control words
//   step_u_np1, step_v_np1 next control words from bkm_control_step
//   step_mode, step_format, step_n, step_u_n, step_v_n   to bkm_control_step
//   busy                   high in ITER and DONE
//   done                   one-cycle pulse, u_res/v_res valid
//   u_res, v_res           final control words, held until overwritten
module bkm_control_seq #(
    parameter int unsigned W     = 64,
    parameter int unsigned LOG2W = 6,
    parameter int unsigned LOG2N = 6
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               srst,
    input  logic               enable,
    input  logic               start,
    input  logic               mode,
    input  logic [1:0]         format,
    input  logic [LOG2N-1:0]   n_last,
    input  logic [W/4-1:0]     u_0,
    input  logic [W/4-1:0]     v_0,
    input  logic [W/4-1:0]     step_u_np1,
    input  logic [W/4-1:0]     step_v_np1,
    output logic               step_mode,
    output logic [1:0]         step_format,
    output logic [LOG2N-1:0]   step_n,
    output logic [W/4-1:0]     step_u_n,
    output logic [W/4-1:0]     step_v_n,
    output logic               busy,
    output logic               done,
    output logic [W/4-1:0]     u_res,
    output logic [W/4-1:0]     v_res
);

    localparam int unsigned CW = W / 4;

    // Elaboration guard: W and LOG2W must describe the same width.
    if ((1 << LOG2W) != W) begin : g_bad_width
        $error("bkm_control_seq: W must equal 2**LOG2W");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LOG2N-1:0]   n_last_q, n_last_d;
    logic               mode_d;
    logic [1:0]         format_d;
    logic [LOG2N-1:0]   n_d;
    logic [CW-1:0]      u_d, v_d, u_res_d, v_res_d;
    logic               busy_d, done_d;

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        n_last_d = n_last_q;
        mode_d   = step_mode;
        format_d = step_format;
        n_d      = step_n;
        u_d      = step_u_n;
        v_d      = step_v_n;
        u_res_d  = u_res;
        v_res_d  = v_res;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_ITER;
                    n_last_d = n_last;
                    mode_d   = mode;
                    format_d = format;
                    n_d      = '0;
                    u_d      = u_0;
                    v_d      = v_0;
                end
            end
            S_ITER: begin
                u_d = step_u_np1;
                v_d = step_v_np1;
                if (step_n == n_last_q) begin
                    // Last iteration: index holds so it never wraps past the maximum.
                    state_d = S_DONE;
                    u_res_d = step_u_np1;
                    v_res_d = step_v_np1;
                end else begin
                    n_d = step_n + LOG2N'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // busy/done are decoded from the next state so they are registered.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers; srst only acts on enabled edges.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= S_IDLE;
            n_last_q    <= '0;
            step_mode   <= 1'b0;
            step_format <= '0;
            step_n      <= '0;
            step_u_n    <= '0;
            step_v_n    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            u_res       <= '0;
            v_res       <= '0;
        end else if (enable) begin
            if (srst) begin
                state_q     <= S_IDLE;
                n_last_q    <= '0;
                step_mode   <= 1'b0;
                step_format <= '0;
                step_n      <= '0;
                step_u_n    <= '0;
                step_v_n    <= '0;
                busy        <= 1'b0;
                done        <= 1'b0;
                u_res       <= '0;
                v_res       <= '0;
            end else begin
                state_q     <= state_d;
                n_last_q    <= n_last_d;
                step_mode   <= mode_d;
                step_format <= format_d;
                step_n      <= n_d;
                step_u_n    <= u_d;
                step_v_n    <= v_d;
                busy        <= busy_d;
                done        <= done_d;
                u_res       <= u_res_d;
                v_res       <= v_res_d;
            end
        end
    end

endmodule

// File: tb/tb_bkm_control_seq.sv
// Self-checking bench for bkm_control_seq with a behavioural step model.
module tb_bkm_control_seq;

    logic        clk = 1'b0;
    logic        arst, srst, enable, start, mode;
    logic [1:0]  format;
    logic [5:0]  n_last;
    logic [15:0] u_0, v_0, step_u_np1, step_v_np1;
    logic        step_mode, busy, done;
    logic [1:0]  step_format;
    logic [5:0]  step_n;
    logic [15:0] step_u_n, step_v_n, u_res, v_res;
    logic [74:0] all_out;

    int total = 0;
    int bad   = 0;
    int model_sel = 0;

    bkm_control_seq #(.W(64), .LOG2W(6), .LOG2N(6)) dut (
        .clk(clk), .arst(arst), .srst(srst), .enable(enable), .start(start),
        .mode(mode), .format(format), .n_last(n_last), .u_0(u_0), .v_0(v_0),
        .step_u_np1(step_u_np1), .step_v_np1(step_v_np1),
        .step_mode(step_mode), .step_format(step_format), .step_n(step_n),
        .step_u_n(step_u_n), .step_v_n(step_v_n), .busy(busy), .done(done),
        .u_res(u_res), .v_res(v_res)
    );

    always #5 clk = ~clk;

    assign all_out = {step_mode, step_format, step_n, step_u_n, step_v_n,
                      busy, done, u_res, v_res};

    // Step model: 0 -> (u+1, v-1); 1 -> (u+n, v+2n).
    always_comb begin
        if (model_sel == 0) begin
            step_u_np1 = step_u_n + 16'd1;
            step_v_np1 = step_v_n - 16'd1;
        end else begin
            step_u_np1 = step_u_n + 16'(step_n);
            step_v_np1 = step_v_n + 16'(step_n) + 16'(step_n);
        end
    end

    typedef struct {
        logic        md;
        logic [1:0]  fmt;
        logic [5:0]  nl;
        logic [15:0] u0;
        logic [15:0] v0;
        int          model;
        logic [15:0] eu;
        logic [15:0] ev;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full run; gap is the percentage of cycles with enable low.
    task automatic run_vec(input vec_t v, input int gap);
        int cycles;
        int guard;
        bit seen;
        model_sel = v.model;
        enable = 1'b1;
        start  = 1'b1;
        mode   = v.md;
        format = v.fmt;
        n_last = v.nl;
        u_0    = v.u0;
        v_0    = v.v0;
        tick();
        start  = 1'b0;
        mode   = ~v.md;
        format = ~v.fmt;
        n_last = '0;
        u_0    = ~v.u0;
        v_0    = ~v.v0;
        check("start_n", 80'(step_n), 80'd0);
        check("start_u", 80'(step_u_n), 80'(v.u0));
        check("start_v", 80'(step_v_n), 80'(v.v0));
        check("start_busy", 80'(busy), 80'd1);
        cycles = 0;
        guard  = 0;
        seen   = 0;
        while (!seen && guard < 400) begin
            enable = ($urandom_range(0, 99) >= 32'(gap));
            tick();
            guard++;
            if (enable) cycles++;
            if (done) seen = 1;
        end
        check("done_timeout", 80'(seen), 80'd1);
        check("latency", 80'(cycles), 80'(v.nl) + 80'd1);
        check("u_res", 80'(u_res), 80'(v.eu));
        check("v_res", 80'(v_res), 80'(v.ev));
        check("u_n_eq_res", 80'(step_u_n), 80'(v.eu));
        check("final_n", 80'(step_n), 80'(v.nl));
        check("done_busy", 80'(busy), 80'd1);
        check("mode_held", {77'd0, step_mode, step_format}, {77'd0, v.md, v.fmt});
        if (gap > 0) begin
            enable = 1'b0;
            tick();
            tick();
            check("done_hold_en0", 80'(done), 80'd1);
        end
        enable = 1'b1;
        tick();
        check("done_pulse_end", 80'(done), 80'd0);
        check("idle_busy", 80'(busy), 80'd0);
        check("res_held", 80'(u_res), 80'(v.eu));
    endtask

    initial begin
        int guard;
        bit seen;

        vecs[0] = '{1'b0, 2'd1, 6'd0,  16'h1234, 16'h0010, 0, 16'h1235, 16'h000F};
        vecs[1] = '{1'b1, 2'd2, 6'd63, 16'h0100, 16'h0000, 1, 16'h08E0, 16'h0FC0};
        vecs[2] = '{1'b0, 2'd3, 6'd63, 16'hFFF0, 16'hF000, 1, 16'h07D0, 16'hFFC0};
        vecs[3] = '{1'b1, 2'd0, 6'd5,  16'hAAAA, 16'h5555, 0, 16'hAAB0, 16'h554F};
        vecs[4] = '{1'b1, 2'd1, 6'd15, 16'h0000, 16'h0000, 1, 16'h0078, 16'h00F0};
        vecs[5] = '{1'b0, 2'd0, 6'd0,  16'h0000, 16'h0000, 0, 16'h0001, 16'hFFFF};

        arst = 1'b1; srst = 1'b0; enable = 1'b0; start = 1'b0; mode = 1'b0;
        format = '0; n_last = '0; u_0 = '0; v_0 = '0;
        tick();
        tick();
        arst = 1'b0;
        enable = 1'b1;
        tick();
        check("reset_state", 80'(all_out), 80'd0);

        // Directed table: single step, full 64-iteration runs, short runs.
        for (int i = 0; i < 5; i++) run_vec(vecs[i], 0);

        // Same n_last=15 run with enable gaps must give the same result.
        run_vec(vecs[4], 30);

        // start while busy is ignored; the following start in IDLE is accepted.
        model_sel = 0;
        start = 1'b1; n_last = 6'd7; u_0 = 16'h0100; v_0 = 16'h0200;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("busy_n3", 80'(step_n), 80'd3);
        start = 1'b1; u_0 = 16'h0000; n_last = 6'd0;
        tick();
        start = 1'b0;
        check("ignored_start_n", 80'(step_n), 80'd4);
        guard = 0; seen = 0;
        while (!seen && guard < 50) begin
            tick();
            guard++;
            if (done) seen = 1;
        end
        check("busy_start_done", 80'(seen), 80'd1);
        check("busy_start_u", 80'(u_res), 80'h0108);
        check("busy_start_v", 80'(v_res), 80'h01F8);
        tick();
        run_vec(vecs[5], 0);

        // Asynchronous reset at n=5 aborts with no done pulse.
        model_sel = 1;
        start = 1'b1; n_last = 6'd20; u_0 = 16'h0042; v_0 = 16'h0024;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("arst_pre_n", 80'(step_n), 80'd5);
        #2 arst = 1'b1;
        #1;
        check("arst_async", 80'(all_out), 80'd0);
        tick();
        arst = 1'b0;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done || busy) seen = 1;
        end
        check("arst_no_done", 80'(seen), 80'd0);

        // srst ignored while enable is low, effective when enable is high.
        start = 1'b1; n_last = 6'd20; u_0 = 16'h0042; v_0 = 16'h0024;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        enable = 1'b0;
        srst = 1'b1;
        tick();
        check("srst_en0_n", 80'(step_n), 80'd3);
        check("srst_en0_busy", 80'(busy), 80'd1);
        enable = 1'b1;
        tick();
        srst = 1'b0;
        check("srst_clear", 80'(all_out), 80'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
